// File: rtl/uart_lite_loopback_buffered.sv
// AXI4-Lite echo engine for a UART-Lite style peripheral.
// Polls status, buffers RX bytes in a FIFO, and refills TX from it.
module uart_lite_loopback_buffered #(
    parameter int                  ADDR_W      = 4,
    parameter int                  DATA_W      = 32,
    parameter int                  FIFO_DEPTH  = 16,
    parameter logic [ADDR_W-1:0]   RX_OFFSET   = 'h0,
    parameter logic [ADDR_W-1:0]   TX_OFFSET   = 'h4,
    parameter logic [ADDR_W-1:0]   STAT_OFFSET = 'h8,
    parameter int                  RX_VLD_BIT  = 0,
    parameter int                  TX_FULL_BIT = 3,
    parameter logic [DATA_W/8-1:0] WSTRB_VAL   = 'b0001
) (
    input  logic                          CLK,
    input  logic                          RST_N,
    input  logic                          ENABLE,
    input  logic                          ERR_CLR,
    output logic [ADDR_W-1:0]             ARADDR,
    output logic                          ARVALID,
    input  logic                          ARREADY,
    input  logic [DATA_W-1:0]             RDATA,
    input  logic [1:0]                    RRESP,
    input  logic                          RVALID,
    output logic                          RREADY,
    output logic [ADDR_W-1:0]             AWADDR,
    output logic                          AWVALID,
    input  logic                          AWREADY,
    output logic [DATA_W-1:0]             WDATA,
    output logic [DATA_W/8-1:0]           WSTRB,
    output logic                          WVALID,
    input  logic                          WREADY,
    input  logic [1:0]                    BRESP,
    input  logic                          BVALID,
    output logic                          BREADY,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          ERR,
    output logic                          BUSY
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int STB_W = DATA_W / 8;

    typedef enum logic [2:0] {
        IDLE,
        STAT_AR,
        STAT_R,
        RX_AR,
        RX_R,
        TX_AW,
        TX_B
    } state_e;

    state_e state_q, state_d;

    logic              arvalid_q, arvalid_d;
    logic [ADDR_W-1:0] araddr_q,  araddr_d;
    logic              rready_q,  rready_d;
    logic              awvalid_q, awvalid_d;
    logic [ADDR_W-1:0] awaddr_q,  awaddr_d;
    logic              wvalid_q,  wvalid_d;
    logic [DATA_W-1:0] wdata_q,   wdata_d;
    logic [STB_W-1:0]  wstrb_q,   wstrb_d;
    logic              bready_q,  bready_d;
    logic              aw_done_q, aw_done_d;
    logic              w_done_q,  w_done_d;
    logic              prio_q,    prio_d;
    logic              err_q,     err_d;
    logic              busy_q,    busy_d;
    logic [CNT_W-1:0]  count_q,   count_d;
    logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;

    logic [DATA_W-1:0] mem [FIFO_DEPTH];

    logic push;
    logic pop;
    logic err_set;
    logic rx_ok;
    logic tx_ok;
    logic serve_rx;
    logic serve_tx;
    logic aw_fire;
    logic w_fire;

    // Service decision taken from the status word; prio_q=0 favours RX.
    always_comb begin
        rx_ok    = RDATA[RX_VLD_BIT] && (count_q < CNT_W'(FIFO_DEPTH));
        tx_ok    = !RDATA[TX_FULL_BIT] && (count_q != '0);
        serve_rx = rx_ok && (!tx_ok || !prio_q);
        serve_tx = tx_ok && (!rx_ok || prio_q);
        aw_fire  = awvalid_q && AWREADY;
        w_fire   = wvalid_q && WREADY;
    end

    // Next-state and registered-output logic for the polling scheduler.
    always_comb begin
        state_d   = state_q;
        arvalid_d = arvalid_q;
        araddr_d  = araddr_q;
        rready_d  = rready_q;
        awvalid_d = awvalid_q;
        awaddr_d  = awaddr_q;
        wvalid_d  = wvalid_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        bready_d  = bready_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;
        prio_d    = prio_q;
        push      = 1'b0;
        pop       = 1'b0;
        err_set   = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (ENABLE) begin
                    state_d   = STAT_AR;
                    arvalid_d = 1'b1;
                    araddr_d  = STAT_OFFSET;
                end
            end
            STAT_AR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = STAT_R;
                end
            end
            STAT_R: begin
                if (RVALID) begin
                    rready_d = 1'b0;
                    state_d  = IDLE;
                    if (RRESP != 2'b00) begin
                        err_set = 1'b1;
                    end else if (serve_rx) begin
                        state_d   = RX_AR;
                        arvalid_d = 1'b1;
                        araddr_d  = RX_OFFSET;
                    end else if (serve_tx) begin
                        state_d   = TX_AW;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        awaddr_d  = TX_OFFSET;
                        wdata_d   = mem[rd_ptr_q];
                        wstrb_d   = WSTRB_VAL;
                    end
                    if (RRESP == 2'b00 && rx_ok && tx_ok) begin
                        prio_d = !prio_q;
                    end
                end
            end
            RX_AR: begin
                if (ARREADY) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RX_R;
                end
            end
            RX_R: begin
                if (RVALID) begin
                    rready_d = 1'b0;
                    state_d  = IDLE;
                    if (RRESP == 2'b00) begin
                        push = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            TX_AW: begin
                if (aw_fire) begin
                    awvalid_d = 1'b0;
                    aw_done_d = 1'b1;
                end
                if (w_fire) begin
                    wvalid_d = 1'b0;
                    w_done_d = 1'b1;
                end
                if ((aw_done_q || aw_fire) && (w_done_q || w_fire)) begin
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                    bready_d  = 1'b1;
                    state_d   = TX_B;
                end
            end
            TX_B: begin
                if (BVALID) begin
                    bready_d = 1'b0;
                    pop      = 1'b1;
                    state_d  = IDLE;
                    if (BRESP != 2'b00) begin
                        err_set = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FIFO bookkeeping, sticky error and busy flag.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
            count_d  = count_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
            count_d  = count_q - CNT_W'(1);
        end
        err_d = ERR_CLR ? 1'b0 : err_q;
        if (err_set) begin
            err_d = 1'b1;
        end
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any transfer.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= IDLE;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            awvalid_q <= 1'b0;
            awaddr_q  <= '0;
            wvalid_q  <= 1'b0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            bready_q  <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
            prio_q    <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            arvalid_q <= arvalid_d;
            araddr_q  <= araddr_d;
            rready_q  <= rready_d;
            awvalid_q <= awvalid_d;
            awaddr_q  <= awaddr_d;
            wvalid_q  <= wvalid_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            bready_q  <= bready_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
            prio_q    <= prio_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            count_q   <= count_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
        end
    end

    // FIFO storage; contents need no reset since count gates use.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem[wr_ptr_q] <= RDATA;
        end
    end

    assign ARVALID    = arvalid_q;
    assign ARADDR     = araddr_q;
    assign RREADY     = rready_q;
    assign AWVALID    = awvalid_q;
    assign AWADDR     = awaddr_q;
    assign WVALID     = wvalid_q;
    assign WDATA      = wdata_q;
    assign WSTRB      = wstrb_q;
    assign BREADY     = bready_q;
    assign FIFO_COUNT = count_q;
    assign ERR        = err_q;
    assign BUSY       = busy_q;

endmodule
